// File: rtl/memory_vr_pkg.sv
// memory_pkg: shared types and elaboration helpers for the memory_vr block.
//   state_t    - controller state (INIT clears the array, RUN serves requests)
//   RD_LAT_*   - legal bounds of the registered read latency
//   mem_clog2  - ceil(log2(v)) with a floor of 1, used to size counters/pointers
//   params_ok  - parameter-legality check evaluated at elaboration
package memory_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int mem_clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int addr_w, input int rd_lat);
    return (width > 0) && ((width % 8) == 0) && (depth > 0) &&
           (depth <= (1 << addr_w)) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/memory_vr_rsp_fifo.sv
// mem_rsp_fifo: synchronous FIFO holding read responses until the consumer
// takes them. Any DEPTH >= 1 is allowed (pointers wrap explicitly).
//   clk, rst        - clock, synchronous active-high reset (control only)
//   i_push/i_push_data - write side; a push while full is ignored
//   i_pop           - read side; a pop while empty is ignored
//   o_pop_data      - head entry (meaningful only when o_count != 0)
//   o_count         - number of stored entries
module mem_rsp_fifo
  import memory_pkg::*;
#(
  parameter int  W     = 17,
  parameter int  DEPTH = 2,
  localparam int CW    = mem_clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_pop_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = mem_clog2(DEPTH);

  logic [W-1:0]  r_buf [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push_ok = i_push && (r_count != CW'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_buf[r_wr_ptr] <= i_push_data;
  end

  assign o_pop_data = r_buf[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/memory_vr.sv
// memory_vr: single-port synchronous memory with a valid/ready request port,
// byte write strobes and a credit-limited, RD_LAT-cycle read response path.
// After every reset the whole array is filled with INIT_VAL before any
// request is accepted.
//   clk, rst              - clock, synchronous active-high reset
//   valid/ready           - request handshake (ready depends on state only)
//   w_en, r_en            - request carries a write and/or a read
//   addr, w_data, w_strb  - word address, write data, byte enables
//   r_valid/r_ready       - response handshake
//   r_data, r_err         - response data; r_err flags addr >= DEPTH
//   init_done             - high once the clearing pass has finished
module memory_vr
  import memory_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 128,
  parameter int               ADDR_WIDTH = 7,
  parameter int               RD_LAT     = 1,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      w_data,
  input  logic [WIDTH/8-1:0]    w_strb,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [WIDTH-1:0]      r_data,
  output logic                  r_err,
  output logic                  init_done
);

  localparam int NB    = WIDTH / 8;
  localparam int CNT_W = mem_clog2(DEPTH);
  localparam int FCW   = mem_clog2(RD_LAT + 2);

  if (!params_ok(WIDTH, DEPTH, ADDR_WIDTH, RD_LAT)) begin : g_param_err
    $error("memory_vr: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           r_state;
  logic [CNT_W-1:0] r_init_cnt;
  logic             r_init_done;
  logic [FCW-1:0]   r_credits;

  logic             w_ready;
  logic             w_acc;
  logic             w_in_range;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_pop;
  logic             w_rsp_valid;
  logic [WIDTH:0]   w_rd_word;
  logic             w_push;
  logic [WIDTH:0]   w_push_data;
  logic [WIDTH:0]   w_fifo_data;
  logic [FCW-1:0]   w_fifo_count;

  // Credits bound the reads in flight to what the response FIFO can hold,
  // so ready never needs to look at the request itself.
  assign w_ready    = (r_state == RUN) && (r_credits != '0);
  assign w_acc      = valid && w_ready && !rst;
  assign w_in_range = int'(addr) < DEPTH;
  assign w_rd_acc   = w_acc && r_en;
  assign w_wr_acc   = w_acc && w_en && w_in_range;
  assign w_pop      = w_rsp_valid && r_ready;
  // MSB carries the error flag; out-of-range reads return zero data.
  assign w_rd_word  = w_in_range ? {1'b0, mem[addr]} : {1'b1, {WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_init_cnt == CNT_W'(DEPTH - 1)) begin
            r_state     <= RUN;
            r_init_done <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // Array has no reset of its own; the INIT walk is the only clear.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == INIT)) begin
      mem[r_init_cnt] <= INIT_VAL;
    end else if (w_wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (w_strb[k]) mem[addr][k*8 +: 8] <= w_data[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= FCW'(RD_LAT + 1);
    end else begin
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // The FIFO write is the last latency stage, so RD_LAT-1 registers precede it.
  if (RD_LAT == 1) begin : g_lat1
    assign w_push      = w_rd_acc;
    assign w_push_data = w_rd_word;
  end else begin : g_pipe
    logic [WIDTH:0] r_data_p [RD_LAT-1];
    logic           r_vld_p  [RD_LAT-1];

    // stage p0: array read captured at the accept edge
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < RD_LAT - 1; i++) r_vld_p[i] <= 1'b0;
      end else begin
        r_vld_p[0] <= w_rd_acc;
        for (int i = 1; i < RD_LAT - 1; i++) r_vld_p[i] <= r_vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      r_data_p[0] <= w_rd_word;
      for (int i = 1; i < RD_LAT - 1; i++) r_data_p[i] <= r_data_p[i-1];
    end

    assign w_push      = r_vld_p[RD_LAT-2];
    assign w_push_data = r_data_p[RD_LAT-2];
  end

  mem_rsp_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (RD_LAT + 1)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign w_rsp_valid = (w_fifo_count != '0);
  assign ready       = w_ready;
  assign r_valid     = w_rsp_valid;
  assign r_data      = w_rsp_valid ? w_fifo_data[WIDTH-1:0] : '0;
  assign r_err       = w_rsp_valid && w_fifo_data[WIDTH];
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_memory_vr.sv
// Testbench for memory_vr. Two instances share one request/response bus:
// dut_a uses the default parameters, dut_b has DEPTH=100, RD_LAT=2 and a
// non-zero INIT_VAL so out-of-range addresses and a longer latency exist.
// 'sel' chooses which instance sees valid; responses are checked against a
// word-array model and an ordered expectation queue per instance.
module tb_memory_vr;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, w_en, r_en, r_ready;
  logic [6:0]  addr;
  logic [15:0] w_data;
  logic [1:0]  w_strb;
  bit          sel;

  logic        ready_a, r_valid_a, r_err_a, init_done_a;
  logic [15:0] r_data_a;
  logic        ready_b, r_valid_b, r_err_b, init_done_b;
  logic [15:0] r_data_b;
  logic        valid_a, valid_b, ready_m;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          lat_on = 1'b0;
  bit          rnd_rr = 1'b0;
  logic [15:0] mdl [2][128];
  exp_t        q0[$];
  exp_t        q1[$];

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;
  assign ready_m = sel ? ready_b : ready_a;

  memory_vr dut_a (
    .clk(clk), .rst(rst), .valid(valid_a), .ready(ready_a), .w_en(w_en),
    .r_en(r_en), .addr(addr), .w_data(w_data), .w_strb(w_strb),
    .r_valid(r_valid_a), .r_ready(r_ready), .r_data(r_data_a),
    .r_err(r_err_a), .init_done(init_done_a)
  );

  memory_vr #(.WIDTH(16), .DEPTH(100), .ADDR_WIDTH(7), .RD_LAT(2),
              .INIT_VAL(16'h5A5A)) dut_b (
    .clk(clk), .rst(rst), .valid(valid_b), .ready(ready_b), .w_en(w_en),
    .r_en(r_en), .addr(addr), .w_data(w_data), .w_strb(w_strb),
    .r_valid(r_valid_b), .r_ready(r_ready), .r_data(r_data_b),
    .r_err(r_err_b), .init_done(init_done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dep_of(input bit s);
    return s ? 100 : 128;
  endfunction

  function automatic int lat_of(input bit s);
    return s ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (r_valid_a && r_ready) begin
      if (q0.size() == 0) chk("spurious_rsp_a", 1, 0);
      else begin
        e = q0.pop_front();
        chk("rdata_a", r_data_a, e.d);
        chk("rerr_a", r_err_a, e.e);
        if (lat_on) chk("latency_a", cyc - e.acc, lat_of(1'b0));
      end
    end
    if (r_valid_b && r_ready) begin
      if (q1.size() == 0) chk("spurious_rsp_b", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rdata_b", r_data_b, e.d);
        chk("rerr_b", r_err_b, e.e);
        if (lat_on) chk("latency_b", cyc - e.acc, lat_of(1'b1));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic do_req(input bit s, input bit we, input bit re, input logic [6:0] a,
                        input logic [15:0] wd, input logic [1:0] st);
    exp_t e;
    bit   ok;
    int   n;
    sel = s; valid = 1'b1; w_en = we; r_en = re; addr = a; w_data = wd; w_strb = st;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (ready_m) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        if (rnd_rr) r_ready = 1'b1;
        n++;
      end
    end
    if (!ok) begin
      chk("req_accept_timeout", 0, 1);
      valid = 1'b0; w_en = 1'b0; r_en = 1'b0;
      return;
    end
    if (re) begin
      e.d   = (int'(a) < dep_of(s)) ? mdl[s][a] : 16'h0000;
      e.e   = (int'(a) >= dep_of(s));
      e.acc = cyc;
      if (s) q1.push_back(e); else q0.push_back(e);
    end
    if (we && int'(a) < dep_of(s)) begin
      for (int k = 0; k < 2; k++)
        if (st[k]) mdl[s][a][k*8 +: 8] = wd[k*8 +: 8];
    end
    @(posedge clk); #1;
    valid = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    r_ready = 1'b1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_empty", q0.size() + q1.size(), 0);
  endtask

  task automatic dump_chk(input string tag);
    int ea, eb;
    ea = 0; eb = 0;
    for (int i = 0; i < 128; i++) if (dut_a.mem[i] !== mdl[0][i]) ea++;
    for (int i = 0; i < 100; i++) if (dut_b.mem[i] !== mdl[1][i]) eb++;
    chk({tag, "_a"}, ea, 0);
    chk({tag, "_b"}, eb, 0);
  endtask

  // Called at posedge+1 right after the last reset edge.
  task automatic init_phase();
    int na, nb;
    bit da, db;
    na = 0; nb = 0; da = 1'b0; db = 1'b0;
    for (int n = 0; n < 400 && !(da && db); n++) begin
      @(negedge clk);
      if (n == 0) begin
        chk("rst_ready_a", ready_a, 0);
        chk("rst_rvalid_a", r_valid_a, 0);
        chk("rst_rdata_a", r_data_a, 0);
        chk("rst_rerr_a", r_err_a, 0);
        chk("rst_idone_a", init_done_a, 0);
        chk("rst_ready_b", ready_b, 0);
        chk("rst_rvalid_b", r_valid_b, 0);
        chk("rst_idone_b", init_done_b, 0);
      end
      if (!da) begin
        if (ready_a) begin da = 1'b1; chk("idone_a", init_done_a, 1); end
        else na++;
      end
      if (!db) begin
        if (ready_b) begin db = 1'b1; chk("idone_b", init_done_b, 1); end
        else nb++;
      end
    end
    chk("init_len_a", na, 128);
    chk("init_len_b", nb, 100);
    for (int i = 0; i < 128; i++) begin
      mdl[0][i] = 16'h0000;
      mdl[1][i] = 16'h5A5A;
    end
    dump_chk("init_dump");
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; w_en = 1'b0; r_en = 1'b0; addr = '0;
    w_data = '0; w_strb = '0; r_ready = 1'b0; sel = 1'b0;

    // 1: INIT clear after a 2-cycle reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_phase();

    // 2: full write then back-to-back reads with latency checking
    for (int i = 0; i < 128; i++) do_req(1'b0, 1'b1, 1'b0, 7'(i), 16'($urandom()), 2'b11);
    r_ready = 1'b1;
    lat_on  = 1'b1;
    for (int i = 0; i < 128; i++) do_req(1'b0, 1'b0, 1'b1, 7'(i), 16'h0, 2'b00);
    for (int i = 0; i < 100; i++) do_req(1'b1, 1'b0, 1'b1, 7'(i), 16'h0, 2'b00);
    drain();
    lat_on = 1'b0;

    // 3: byte strobes
    do_req(1'b0, 1'b1, 1'b0, 7'd5, 16'hABCD, 2'b11);
    do_req(1'b0, 1'b1, 1'b0, 7'd5, 16'h1234, 2'b01);
    do_req(1'b0, 1'b0, 1'b1, 7'd5, 16'h0, 2'b00);
    drain();
    chk("strb_mem5", dut_a.mem[5], 16'hAB34);

    // 4: backpressure, response hold, no-op beats are credit-free
    r_ready = 1'b0;
    do_req(1'b0, 1'b0, 1'b1, 7'd10, 16'h0, 2'b00);
    do_req(1'b0, 1'b0, 1'b1, 7'd11, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready_low", ready_a, 0);
      chk("bp_rvalid", r_valid_a, 1);
      chk("bp_hold_data", r_data_a, q0[0].d);
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    do_req(1'b0, 1'b0, 1'b1, 7'd12, 16'h0, 2'b00);
    do_req(1'b0, 1'b0, 1'b1, 7'd13, 16'h0, 2'b00);
    drain();
    r_ready = 1'b0;
    do_req(1'b0, 1'b0, 1'b1, 7'd20, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) do_req(1'b0, 1'b0, 1'b0, 7'd21, 16'h0, 2'b00);
    do_req(1'b0, 1'b0, 1'b1, 7'd21, 16'h0, 2'b00);
    drain();

    // 5: same-beat write+read, then out-of-range on the 100-word instance
    do_req(1'b0, 1'b1, 1'b0, 7'd9, 16'h0001, 2'b11);
    do_req(1'b0, 1'b1, 1'b1, 7'd9, 16'h00FF, 2'b11);
    do_req(1'b0, 1'b0, 1'b1, 7'd9, 16'h0, 2'b00);
    drain();
    chk("same_beat_mem9", dut_a.mem[9], 16'h00FF);
    do_req(1'b1, 1'b1, 1'b0, 7'd120, 16'hDEAD, 2'b11);
    do_req(1'b1, 1'b0, 1'b1, 7'd120, 16'h0, 2'b00);
    do_req(1'b1, 1'b0, 1'b1, 7'd99, 16'h0, 2'b00);
    drain();
    dump_chk("oor_dump");

    // randomized mix of writes, reads, no-ops and response stalls
    rnd_rr = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r_ready = 1'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             7'($urandom_range(0, 127)), 16'($urandom()), 2'($urandom_range(0, 3)));
    end
    rnd_rr = 1'b0;
    drain();
    dump_chk("rand_dump");

    // 6: reset with two reads in flight
    r_ready = 1'b0;
    do_req(1'b0, 1'b0, 1'b1, 7'd30, 16'h0, 2'b00);
    do_req(1'b0, 1'b0, 1'b1, 7'd31, 16'h0, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    r_ready = 1'b1;
    init_phase();
    for (int i = 28; i < 34; i++) do_req(1'b0, 1'b0, 1'b1, 7'(i), 16'h0, 2'b00);
    do_req(1'b1, 1'b0, 1'b1, 7'd7, 16'h0, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
